// File: rtl/enigma_cmd_pkg.sv
// Shared opcode/error encodings and switch-word field positions for the Enigma command loader.
package enigma_cmd_pkg;

    typedef enum logic [2:0] {
        OpNop        = 3'd0,
        OpSetPos     = 3'd1,
        OpSetSel     = 3'd2,
        OpPlug       = 3'd3,
        OpLetter     = 3'd4,
        OpCommit     = 3'd5,
        OpClearPlugs = 3'd6,
        OpRsvd       = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ErrNone         = 3'd0,
        ErrBadOp        = 3'd1,
        ErrBadIdx       = 3'd2,
        ErrBadLetter    = 3'd3,
        ErrPlugFull     = 3'd4,
        ErrPlugConflict = 3'd5,
        ErrBusy         = 3'd6,
        ErrNoCfg        = 3'd7
    } err_e;

    localparam int unsigned SwWidth   = 16;
    localparam int unsigned SwOpMsb   = 15;
    localparam int unsigned SwOpLsb   = 13;
    localparam int unsigned SwIdxMsb  = 12;
    localparam int unsigned SwIdxLsb  = 10;
    localparam int unsigned SwValBMsb = 9;
    localparam int unsigned SwValBLsb = 5;
    localparam int unsigned SwValAMsb = 4;
    localparam int unsigned SwValALsb = 0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge detector for one button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
        end
    end

    // Counter only runs while the synchronised level disagrees; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            level_d = sync_q[1];
        end else if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign press = level_q & ~prev_q;

endmodule

// File: rtl/enigma_cmd_loader.sv
// Switch/button command front-end: decodes one command per debounced press, keeps shadow and
// active rotor/plugboard configuration, and offers letters and committed config via valid/ready.
module enigma_cmd_loader
    import enigma_cmd_pkg::*;
#(
    parameter int unsigned NUM_ROTORS      = 3,
    parameter int unsigned ROTOR_SEL_W     = 3,
    parameter int unsigned LETTER_W        = 5,
    parameter int unsigned ALPHABET        = 26,
    parameter int unsigned PLUG_PAIRS      = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [15:0]                         sw,
    input  logic                                data_valid_in,
    input  logic                                cfg_ready_in,
    input  logic                                letter_ready_in,
    output logic                                cfg_valid_out,
    output logic [NUM_ROTORS*ROTOR_SEL_W-1:0]   rotor_select_out,
    output logic [NUM_ROTORS*LETTER_W-1:0]      rotor_initial_out,
    output logic [PLUG_PAIRS*2*LETTER_W-1:0]    plug_pairs_out,
    output logic [$clog2(PLUG_PAIRS+1)-1:0]     plug_count_out,
    output logic                                letter_valid_out,
    output logic [LETTER_W-1:0]                 char_out,
    output logic                                err_valid_out,
    output logic [2:0]                          err_code_out
);

    localparam int unsigned PcW   = $clog2(PLUG_PAIRS + 1);
    localparam int unsigned PairW = 2 * LETTER_W;

    logic press, exec_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .btn_raw (data_valid_in),
        .press   (press)
    );

    op_e                 op;
    logic [2:0]          idx;
    logic [4:0]          val_a, val_b;
    logic [LETTER_W-1:0] a_l, b_l;

    assign op    = op_e'(sw[SwOpMsb:SwOpLsb]);
    assign idx   = sw[SwIdxMsb:SwIdxLsb];
    assign val_b = sw[SwValBMsb:SwValBLsb];
    assign val_a = sw[SwValAMsb:SwValALsb];
    assign a_l   = LETTER_W'(val_a);
    assign b_l   = LETTER_W'(val_b);

    logic [ROTOR_SEL_W-1:0] sh_sel_q  [NUM_ROTORS];
    logic [ROTOR_SEL_W-1:0] sh_sel_d  [NUM_ROTORS];
    logic [ROTOR_SEL_W-1:0] act_sel_q [NUM_ROTORS];
    logic [ROTOR_SEL_W-1:0] act_sel_d [NUM_ROTORS];
    logic [LETTER_W-1:0]    sh_pos_q  [NUM_ROTORS];
    logic [LETTER_W-1:0]    sh_pos_d  [NUM_ROTORS];
    logic [LETTER_W-1:0]    act_pos_q [NUM_ROTORS];
    logic [LETTER_W-1:0]    act_pos_d [NUM_ROTORS];
    logic [PairW-1:0]       sh_pair_q [PLUG_PAIRS];
    logic [PairW-1:0]       sh_pair_d [PLUG_PAIRS];
    logic [PairW-1:0]       act_pair_q[PLUG_PAIRS];
    logic [PairW-1:0]       act_pair_d[PLUG_PAIRS];
    logic [PcW-1:0]         sh_cnt_q, sh_cnt_d, act_cnt_q, act_cnt_d;

    logic                configured_q, configured_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                letter_valid_q, letter_valid_d;
    logic [LETTER_W-1:0] char_q, char_d;
    logic                err_valid_q, err_valid_d;
    err_e                err_code_q, err_code_d;

    logic idx_bad, letter_bad, plug_conflict;
    err_e err;

    always_comb begin
        idx_bad       = (32'(idx) >= NUM_ROTORS);
        plug_conflict = (val_a == val_b);
        for (int j = 0; j < PLUG_PAIRS; j++) begin
            if (PcW'(j) < sh_cnt_q) begin
                if (sh_pair_q[j][LETTER_W-1:0] == a_l || sh_pair_q[j][PairW-1:LETTER_W] == a_l ||
                    sh_pair_q[j][LETTER_W-1:0] == b_l || sh_pair_q[j][PairW-1:LETTER_W] == b_l) begin
                    plug_conflict = 1'b1;
                end
            end
        end
        letter_bad = 1'b0;
        if (op == OpSetPos || op == OpLetter) begin
            letter_bad = (32'(val_a) >= ALPHABET);
        end else if (op == OpPlug) begin
            letter_bad = (32'(val_a) >= ALPHABET) || (32'(val_b) >= ALPHABET);
        end

        // Ready is honoured before busy is judged, so a completing handshake frees the slot.
        err = ErrNone;
        if (op == OpRsvd) begin
            err = ErrBadOp;
        end else if ((op == OpSetPos || op == OpSetSel) && idx_bad) begin
            err = ErrBadIdx;
        end else if (letter_bad) begin
            err = ErrBadLetter;
        end else if (op == OpPlug && sh_cnt_q == PcW'(PLUG_PAIRS)) begin
            err = ErrPlugFull;
        end else if (op == OpPlug && plug_conflict) begin
            err = ErrPlugConflict;
        end else if ((op == OpCommit && cfg_valid_q && !cfg_ready_in) ||
                     (op == OpLetter && letter_valid_q && !letter_ready_in)) begin
            err = ErrBusy;
        end else if (op == OpLetter && !configured_q) begin
            err = ErrNoCfg;
        end
    end

    always_comb begin
        sh_sel_d       = sh_sel_q;
        sh_pos_d       = sh_pos_q;
        sh_pair_d      = sh_pair_q;
        sh_cnt_d       = sh_cnt_q;
        act_sel_d      = act_sel_q;
        act_pos_d      = act_pos_q;
        act_pair_d     = act_pair_q;
        act_cnt_d      = act_cnt_q;
        configured_d   = configured_q;
        cfg_valid_d    = cfg_valid_q && !cfg_ready_in;
        letter_valid_d = letter_valid_q && !letter_ready_in;
        char_d         = char_q;
        err_valid_d    = 1'b0;
        err_code_d     = err_code_q;

        if (exec_q && err != ErrNone) begin
            err_valid_d = 1'b1;
            err_code_d  = err;
        end else if (exec_q) begin
            unique case (op)
                OpSetPos: begin
                    for (int i = 0; i < NUM_ROTORS; i++) begin
                        if (idx == 3'(i)) sh_pos_d[i] = a_l;
                    end
                end
                OpSetSel: begin
                    for (int i = 0; i < NUM_ROTORS; i++) begin
                        if (idx == 3'(i)) sh_sel_d[i] = val_a[ROTOR_SEL_W-1:0];
                    end
                end
                OpPlug: begin
                    for (int j = 0; j < PLUG_PAIRS; j++) begin
                        if (sh_cnt_q == PcW'(j)) sh_pair_d[j] = {b_l, a_l};
                    end
                    sh_cnt_d = sh_cnt_q + PcW'(1);
                end
                OpLetter: begin
                    char_d         = a_l;
                    letter_valid_d = 1'b1;
                end
                OpCommit: begin
                    act_sel_d    = sh_sel_q;
                    act_pos_d    = sh_pos_q;
                    act_pair_d   = sh_pair_q;
                    act_cnt_d    = sh_cnt_q;
                    configured_d = 1'b1;
                    cfg_valid_d  = 1'b1;
                end
                OpClearPlugs: sh_cnt_d = '0;
                OpNop, OpRsvd: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                sh_sel_q[i]  <= ROTOR_SEL_W'(i);
                act_sel_q[i] <= ROTOR_SEL_W'(i);
                sh_pos_q[i]  <= '0;
                act_pos_q[i] <= '0;
            end
            for (int j = 0; j < PLUG_PAIRS; j++) begin
                sh_pair_q[j]  <= '0;
                act_pair_q[j] <= '0;
            end
            sh_cnt_q       <= '0;
            act_cnt_q      <= '0;
            exec_q         <= 1'b0;
            configured_q   <= 1'b0;
            cfg_valid_q    <= 1'b0;
            letter_valid_q <= 1'b0;
            char_q         <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ErrNone;
        end else begin
            sh_sel_q       <= sh_sel_d;
            act_sel_q      <= act_sel_d;
            sh_pos_q       <= sh_pos_d;
            act_pos_q      <= act_pos_d;
            sh_pair_q      <= sh_pair_d;
            act_pair_q     <= act_pair_d;
            sh_cnt_q       <= sh_cnt_d;
            act_cnt_q      <= act_cnt_d;
            exec_q         <= press;
            configured_q   <= configured_d;
            cfg_valid_q    <= cfg_valid_d;
            letter_valid_q <= letter_valid_d;
            char_q         <= char_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
        end
    end

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor_out
        assign rotor_select_out[i*ROTOR_SEL_W +: ROTOR_SEL_W] = act_sel_q[i];
        assign rotor_initial_out[i*LETTER_W +: LETTER_W]      = act_pos_q[i];
    end

    for (genvar j = 0; j < PLUG_PAIRS; j++) begin : g_pair_out
        assign plug_pairs_out[j*PairW +: PairW] = act_pair_q[j];
    end

    assign plug_count_out   = act_cnt_q;
    assign cfg_valid_out    = cfg_valid_q;
    assign letter_valid_out = letter_valid_q;
    assign char_out         = char_q;
    assign err_valid_out    = err_valid_q;
    assign err_code_out     = err_code_q;

endmodule

// File: tb/tb_enigma_cmd_loader.sv
// Directed bench for enigma_cmd_loader with a short debounce window.
module tb_enigma_cmd_loader;

    localparam logic [2:0] OP_NOP = 3'd0, OP_POS = 3'd1, OP_SEL = 3'd2, OP_PLUG = 3'd3;
    localparam logic [2:0] OP_LET = 3'd4, OP_COMMIT = 3'd5, OP_CLR = 3'd6, OP_RSVD = 3'd7;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [15:0] sw = '0;
    logic        data_valid_in = 1'b0;
    logic        cfg_ready_in = 1'b0;
    logic        letter_ready_in = 1'b0;
    logic        cfg_valid_out;
    logic [8:0]  rotor_select_out;
    logic [14:0] rotor_initial_out;
    logic [99:0] plug_pairs_out;
    logic [3:0]  plug_count_out;
    logic        letter_valid_out;
    logic [4:0]  char_out;
    logic        err_valid_out;
    logic [2:0]  err_code_out;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    logic [2:0] err_last = '0;

    enigma_cmd_loader #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .sw               (sw),
        .data_valid_in    (data_valid_in),
        .cfg_ready_in     (cfg_ready_in),
        .letter_ready_in  (letter_ready_in),
        .cfg_valid_out    (cfg_valid_out),
        .rotor_select_out (rotor_select_out),
        .rotor_initial_out(rotor_initial_out),
        .plug_pairs_out   (plug_pairs_out),
        .plug_count_out   (plug_count_out),
        .letter_valid_out (letter_valid_out),
        .char_out         (char_out),
        .err_valid_out    (err_valid_out),
        .err_code_out     (err_code_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (err_valid_out) begin
            err_seen = err_seen + 1;
            err_last = err_code_out;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        data_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    // One full press/release; bounce adds a 1,0 glitch before the steady level.
    task automatic send_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [4:0] vb,
                            input logic [4:0] va, input bit bounce);
        @(negedge clk_in);
        sw = {op, idx, vb, va};
        err_seen = 0;
        if (bounce) begin
            data_valid_in = 1'b1;
            repeat (2) @(negedge clk_in);
            data_valid_in = 1'b0;
            repeat (2) @(negedge clk_in);
        end
        data_valid_in = 1'b1;
        repeat (12) @(negedge clk_in);
        data_valid_in = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        check_eq({tag, "_pulses"}, 128'(err_seen), 128'(1));
        check_eq({tag, "_code"}, 128'(err_last), 128'(code));
    endtask

    initial begin
        logic [4:0] pa [8];
        logic [4:0] pb [8];
        pa = '{5, 7, 10, 12, 14, 16, 18, 20};
        pb = '{6, 8, 11, 13, 15, 17, 19, 21};

        // Reset values
        repeat (2) @(negedge clk_in);
        check_eq("rst_cfg_valid", 128'(cfg_valid_out), 128'(0));
        check_eq("rst_letter_valid", 128'(letter_valid_out), 128'(0));
        check_eq("rst_err_valid", 128'(err_valid_out), 128'(0));
        check_eq("rst_err_code", 128'(err_code_out), 128'(0));
        check_eq("rst_char", 128'(char_out), 128'(0));
        check_eq("rst_plug_count", 128'(plug_count_out), 128'(0));
        check_eq("rst_select", 128'(rotor_select_out), 128'(9'b010_001_000));
        check_eq("rst_initial", 128'(rotor_initial_out), 128'(0));
        check_eq("rst_pairs", 128'(plug_pairs_out), 128'(0));
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Bounce: one command only; a duplicated PLUG would raise a conflict and count 2
        cfg_ready_in = 1'b1;
        send_cmd(OP_POS, 3'd1, 5'd0, 5'd7, 1'b1);
        check_eq("bounce_pos_noerr", 128'(err_seen), 128'(0));
        send_cmd(OP_PLUG, 3'd0, 5'd2, 5'd1, 1'b1);
        check_eq("bounce_plug_noerr", 128'(err_seen), 128'(0));
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("bounce_init1", 128'(rotor_initial_out[9:5]), 128'(7));
        check_eq("bounce_init_other", 128'({rotor_initial_out[14:10], rotor_initial_out[4:0]}),
                 128'(0));
        check_eq("bounce_plug_count", 128'(plug_count_out), 128'(1));

        // Letter handshake
        do_reset();
        cfg_ready_in = 1'b1;
        letter_ready_in = 1'b0;
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        send_cmd(OP_LET, 3'd0, 5'd0, 5'd4, 1'b0);
        check_eq("let_valid", 128'(letter_valid_out), 128'(1));
        check_eq("let_char", 128'(char_out), 128'(4));
        repeat (5) @(negedge clk_in);
        check_eq("let_valid_held", 128'(letter_valid_out), 128'(1));
        send_cmd(OP_LET, 3'd0, 5'd0, 5'd9, 1'b0);
        expect_err("let_busy", 3'd6);
        check_eq("let_char_stable", 128'(char_out), 128'(4));
        letter_ready_in = 1'b1;
        check_eq("let_valid_at_ready", 128'(letter_valid_out), 128'(1));
        @(negedge clk_in);
        letter_ready_in = 1'b0;
        check_eq("let_valid_dropped", 128'(letter_valid_out), 128'(0));

        // Config hold
        do_reset();
        cfg_ready_in = 1'b0;
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("cfg_valid_held", 128'(cfg_valid_out), 128'(1));
        send_cmd(OP_SEL, 3'd0, 5'd0, 5'd5, 1'b0);
        check_eq("cfg_sel_noerr", 128'(err_seen), 128'(0));
        check_eq("cfg_sel0_unchanged", 128'(rotor_select_out[2:0]), 128'(0));
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        expect_err("cfg_busy", 3'd6);
        cfg_ready_in = 1'b1;
        @(negedge clk_in);
        cfg_ready_in = 1'b0;
        check_eq("cfg_valid_dropped", 128'(cfg_valid_out), 128'(0));
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("cfg_sel0_new", 128'(rotor_select_out[2:0]), 128'(5));
        check_eq("cfg_valid_again", 128'(cfg_valid_out), 128'(1));

        // Plugboard
        do_reset();
        cfg_ready_in = 1'b1;
        send_cmd(OP_PLUG, 3'd0, 5'd2, 5'd1, 1'b0);
        send_cmd(OP_PLUG, 3'd0, 5'd4, 5'd3, 1'b0);
        check_eq("plug_legal_noerr", 128'(err_seen), 128'(0));
        send_cmd(OP_PLUG, 3'd0, 5'd9, 5'd2, 1'b0);
        expect_err("plug_conflict_used", 3'd5);
        send_cmd(OP_PLUG, 3'd0, 5'd6, 5'd6, 1'b0);
        expect_err("plug_conflict_same", 3'd5);
        for (int k = 0; k < 8; k++) send_cmd(OP_PLUG, 3'd0, pb[k], pa[k], 1'b0);
        send_cmd(OP_PLUG, 3'd0, 5'd23, 5'd22, 1'b0);
        expect_err("plug_full", 3'd4);
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("plug_count10", 128'(plug_count_out), 128'(10));
        check_eq("plug_pair0", 128'(plug_pairs_out[9:0]), 128'({5'd2, 5'd1}));
        check_eq("plug_pair9", 128'(plug_pairs_out[99:90]), 128'({5'd21, 5'd20}));
        send_cmd(OP_CLR, 3'd0, 5'd0, 5'd0, 1'b0);
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("plug_count_cleared", 128'(plug_count_out), 128'(0));

        // Illegal inputs
        do_reset();
        cfg_ready_in = 1'b1;
        send_cmd(OP_LET, 3'd0, 5'd0, 5'd3, 1'b0);
        expect_err("ill_nocfg", 3'd7);
        check_eq("ill_no_letter", 128'(letter_valid_out), 128'(0));
        send_cmd(OP_POS, 3'd5, 5'd0, 5'd3, 1'b0);
        expect_err("ill_idx", 3'd2);
        send_cmd(OP_POS, 3'd0, 5'd0, 5'd27, 1'b0);
        expect_err("ill_letter", 3'd3);
        send_cmd(OP_RSVD, 3'd0, 5'd0, 5'd0, 1'b0);
        expect_err("ill_op", 3'd1);
        send_cmd(OP_NOP, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("ill_nop_noerr", 128'(err_seen), 128'(0));
        check_eq("ill_code_held", 128'(err_code_out), 128'(1));
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        check_eq("ill_initial", 128'(rotor_initial_out), 128'(0));
        check_eq("ill_select", 128'(rotor_select_out), 128'(9'b010_001_000));

        // Async reset during a pending letter
        do_reset();
        cfg_ready_in = 1'b1;
        letter_ready_in = 1'b0;
        send_cmd(OP_COMMIT, 3'd0, 5'd0, 5'd0, 1'b0);
        send_cmd(OP_LET, 3'd0, 5'd0, 5'd4, 1'b0);
        check_eq("ar_letter_pending", 128'(letter_valid_out), 128'(1));
        #2;
        rst_n_in = 1'b0;
        #1;
        check_eq("ar_letter_valid", 128'(letter_valid_out), 128'(0));
        check_eq("ar_char", 128'(char_out), 128'(0));
        check_eq("ar_cfg_valid", 128'(cfg_valid_out), 128'(0));
        check_eq("ar_err_code", 128'(err_code_out), 128'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        send_cmd(OP_LET, 3'd0, 5'd0, 5'd4, 1'b0);
        expect_err("ar_unconfigured", 3'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enigma_cmd_loader.md
Name: enigma_cmd_loader

Overview:
- Parametrised switch/button command front-end for the Enigma datapath. Takes a 16-bit switch word plus a raw push-button strobe.
- Synchronises and debounces the strobe, then decodes an opcode.
- Maintains shadow and active rotor/plugboard configuration, and emits letters and committed configuration over held valid/ready handshakes.
- Sits between the board I/O and the rotor/plugboard/stepping core; replaces the single-rotor-set, pulse-only loader.

Parameters:
- NUM_ROTORS, 3, rotor count; 1..8.
- ROTOR_SEL_W, 3, bits per rotor-type select; ≤5.
- LETTER_W, 5, bits per letter code.
- ALPHABET, 26, legal letter codes are 0..ALPHABET-1.
- PLUG_PAIRS, 10, maximum plugboard pairs.
- DEBOUNCE_CYCLES, 1_000_000, stable cycles required; 0 = bypass.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset.
- sw, input, 16, command word: [15:13] op, [12:10] idx, [9:5] val_b, [4:0] val_a.
- data_valid_in, input, 1, raw asynchronous button level.
- cfg_ready_in, input, 1, core accepts configuration.
- letter_ready_in, input, 1, core accepts letter.
- cfg_valid_out, output, 1, active configuration offered.
- rotor_select_out, output, NUM_ROTORS*ROTOR_SEL_W, active rotor types; rotor i at slice i.
- rotor_initial_out, output, NUM_ROTORS*LETTER_W, active start positions.
- plug_pairs_out, output, PLUG_PAIRS*2*LETTER_W, active pairs as {b,a}.
- plug_count_out, output, clog2(PLUG_PAIRS+1), active pair count.
- letter_valid_out, output, 1, letter offered.
- char_out, output, LETTER_W, letter.
- err_valid_out, output, 1, one-cycle error pulse.
- err_code_out, output, 3, error cause; holds last code.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n_in).
  - All valids, err_valid_out, err_code_out, char_out, and plug_count_out are 0.
  - Rotor i select = i mod 2^ROTOR_SEL_W. All positions 0. Pairs 0. Shadow equals active.
  - configured flag = 0. Synchroniser, debounce counter and prev-level are 0.
- Input path:
  - 2-flop synchroniser on data_valid_in.
  - Debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
  - A rising edge of the debounced level issues exactly one command.
  - sw is sampled in the execute cycle, which is the cycle after that edge. sw is not synchronised; the user holds it static.
- Opcodes:
  - 000 NOP.
  - 001 SET_POS: shadow position[idx] = val_a.
  - 010 SET_SEL: shadow select[idx] = val_a[ROTOR_SEL_W-1:0].
  - 011 PLUG: appends {val_b, val_a} at shadow index count; count+1.
  - 100 LETTER: char_out = val_a; letter_valid_out = 1.
  - 101 COMMIT: active = shadow; configured = 1; cfg_valid_out = 1.
  - 110 CLEAR_PLUGS: shadow count = 0.
  - 111: error.
- Error codes (command has no other effect; err_valid_out pulses 1 cycle in the execute cycle+1):
  - 1 BAD_OP.
  - 2 BAD_IDX: idx ≥ NUM_ROTORS on 001/010.
  - 3 BAD_LETTER: val ≥ ALPHABET on 001/011/100.
  - 4 PLUG_FULL: count == PLUG_PAIRS.
  - 5 PLUG_CONFLICT: a==b, or a or b already in a shadow pair.
  - 6 BUSY: COMMIT while cfg_valid_out=1, or LETTER while letter_valid_out=1.
  - 7 NO_CFG: LETTER while configured=0.
- Check priority: op > idx > letter > full > conflict > busy > no_cfg.
- Handshakes:
  - A valid stays high, with its data stable, until the cycle in which ready is high.
  - The valid falls the next cycle. Ready while valid=0 is ignored.
- Latency: command effects (valid rise, shadow update) are registered one cycle after the execute cycle.
- Simultaneity:
  - A command and a ready on the same cycle: ready is evaluated first, so a LETTER in the handshake-completing cycle is not BUSY.
  - The shadow may be edited while cfg_valid_out is high; active is unaffected.
- Reset mid-handshake drops the offered data and restores reset values.

Decomposition:
- Package enigma_cmd_pkg holds:
  - op_e enum (NOP..RSVD).
  - err_e enum (NONE=0..NO_CFG=7).
  - sw field bit-position localparams.
- Sub-module: btn_debounce, containing the synchroniser, counter and rising-edge pulse, parametrised by DEBOUNCE_CYCLES.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Bounce: data_valid_in toggles 1,0,1 at 2-cycle spacing, then held high 10 cycles -> exactly one command; a SET_POS idx=1 val=7 then COMMIT gives rotor_initial_out slice1=7.
- Letter handshake: COMMIT, then LETTER val=4 with letter_ready_in=0 for 5 cycles -> letter_valid_out/char_out=4 held 5 cycles; a second LETTER meanwhile -> err 6; ready=1 -> valid drops next cycle.
- Config hold: COMMIT with cfg_ready_in=0 -> cfg_valid_out held; SET_SEL idx=0 val=5 -> active select0 unchanged; COMMIT -> err 6; ready, then COMMIT -> select0=5.
- Plugboard: PLUG (1,2), (3,4), then (2,9) -> err 5; a==b (6,6) -> err 5; 10 legal pairs then an 11th -> err 4; CLEAR_PLUGS + COMMIT -> plug_count_out=0.
- Illegal inputs: LETTER after reset -> err 7; SET_POS idx=5 -> err 2; SET_POS val=27 -> err 3; op 111 -> err 1; no state changes.
- Async reset asserted mid-pending letter_valid_out -> all outputs immediately at reset values; configured=0.
